// File: rtl/cpu_ctrl_seq_pkg.sv
// Shared definitions for the control sequencer: state encodings, opcode classes, CSR map.
package cpu_ctrl_seq_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_FETCH     = 4'd1,
        ST_WAIT_INST = 4'd2,
        ST_DECODE    = 4'd3,
        ST_CALC      = 4'd4,
        ST_MEM_RD    = 4'd5,
        ST_MEM_WR    = 4'd6,
        ST_BRANCH    = 4'd7,
        ST_RETIRE    = 4'd8,
        ST_HALT      = 4'd9,
        ST_ERROR     = 4'd10
    } state_t;

    localparam logic [5:0] OP_NOP   = 6'd0;
    localparam logic [5:0] OP_ALU   = 6'd1;
    localparam logic [5:0] OP_LOAD  = 6'd2;
    localparam logic [5:0] OP_STORE = 6'd3;
    localparam logic [5:0] OP_BE    = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_HALT  = 6'd63;

    localparam int CSR_CTRL        = 0;
    localparam int CSR_STATUS      = 1;
    localparam int CSR_STEP        = 2;
    localparam int CSR_INST_COUNT  = 3;
    localparam int CSR_STALL_COUNT = 4;
    localparam int CSR_TIMEOUT     = 5;

    // States in which the watchdog counts cycles spent waiting on something external.
    function automatic logic is_watched(state_t s);
        return s inside {ST_FETCH, ST_WAIT_INST, ST_CALC, ST_MEM_RD, ST_MEM_WR};
    endfunction

endpackage

// File: rtl/cpu_ctrl_csr.sv
// CSR slave: CTRL/STEP/TIMEOUT registers, saturating perf counters and registered read mux.
module cpu_ctrl_csr
    import cpu_ctrl_seq_pkg::*;
#(
    parameter int          DATA_BITS     = 32,
    parameter int          CSR_ADDR_BITS = 3,
    parameter int unsigned TIMEOUT_RST   = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CSR_ADDR_BITS-1:0] addr,
    input  logic                     read,
    input  logic                     write,
    input  logic [DATA_BITS-1:0]     writedata,
    output logic [DATA_BITS-1:0]     readdata,
    output logic                     readdatavalid,
    input  logic [3:0]               fsm_state,
    input  logic                     halted,
    input  logic                     error,
    input  logic                     inst_done,
    input  logic                     stall,
    output logic                     run,
    output logic                     step_mode,
    output logic                     clear,
    output logic                     step,
    output logic [DATA_BITS-1:0]     timeout
);

    logic [DATA_BITS-1:0] inst_count;
    logic [DATA_BITS-1:0] stall_count;
    logic [DATA_BITS-1:0] rdata;
    logic                 wr_ctrl;
    logic                 wr_step;
    logic                 wr_timeout;

    assign wr_ctrl    = write && (addr == CSR_ADDR_BITS'(CSR_CTRL));
    assign wr_step    = write && (addr == CSR_ADDR_BITS'(CSR_STEP));
    assign wr_timeout = write && (addr == CSR_ADDR_BITS'(CSR_TIMEOUT));

    always_comb begin
        rdata = '0;
        case (addr)
            CSR_ADDR_BITS'(CSR_CTRL):        rdata = DATA_BITS'({step_mode, run});
            CSR_ADDR_BITS'(CSR_STATUS):      rdata = DATA_BITS'({error, halted, fsm_state});
            CSR_ADDR_BITS'(CSR_INST_COUNT):  rdata = inst_count;
            CSR_ADDR_BITS'(CSR_STALL_COUNT): rdata = stall_count;
            CSR_ADDR_BITS'(CSR_TIMEOUT):     rdata = timeout;
            default:                         rdata = '0;
        endcase
    end

    // clear and step are one-cycle pulses seen by the FSM the cycle after the write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            run           <= 1'b0;
            step_mode     <= 1'b0;
            clear         <= 1'b0;
            step          <= 1'b0;
            timeout       <= DATA_BITS'(TIMEOUT_RST);
            inst_count    <= '0;
            stall_count   <= '0;
            readdata      <= '0;
            readdatavalid <= 1'b0;
        end else begin
            clear <= 1'b0;
            step  <= wr_step;
            if (wr_ctrl) begin
                run       <= writedata[0];
                step_mode <= writedata[1];
                clear     <= writedata[2];
            end
            if (wr_timeout) begin
                timeout <= writedata;
            end
            if (clear) begin
                inst_count  <= '0;
                stall_count <= '0;
            end else begin
                if (inst_done && (inst_count != '1)) begin
                    inst_count <= inst_count + DATA_BITS'(1);
                end
                if (stall && (stall_count != '1)) begin
                    stall_count <= stall_count + DATA_BITS'(1);
                end
            end
            readdatavalid <= read;
            readdata      <= read ? rdata : '0;
        end
    end

endmodule

// File: rtl/cpu_ctrl_seq.sv
// Instruction sequencer: fetch/decode FSM with per-phase watchdog, driving ALU/memory/branch.
// Unit handshake: start is a one-cycle pulse on state entry; complete is sampled every cycle from then on, start cycle included.
module cpu_ctrl_seq
    import cpu_ctrl_seq_pkg::*;
#(
    parameter int          INST_BITS     = 32,
    parameter int          DATA_BITS     = 32,
    parameter int          CSR_ADDR_BITS = 3,
    parameter int unsigned TIMEOUT_RST   = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_empty,
    output logic                     o_fetch_req,
    input  logic [INST_BITS-1:0]     i_inst,
    input  logic                     i_inst_valid,
    output logic                     o_calc_start,
    output logic [5:0]               o_calc_op,
    input  logic                     i_calc_complete,
    output logic                     o_read_mem_start,
    input  logic                     i_read_mem_complete,
    output logic                     o_write_mem_start,
    input  logic                     i_write_mem_complete,
    input  logic [DATA_BITS-1:0]     i_src0,
    input  logic [DATA_BITS-1:0]     i_src1,
    output logic                     o_be_bne,
    output logic                     o_inst_complete,
    output logic                     o_halted,
    output logic                     o_error,
    input  logic [CSR_ADDR_BITS-1:0] i_addr,
    input  logic                     i_read,
    input  logic                     i_write,
    input  logic [DATA_BITS-1:0]     i_writedata,
    output logic [DATA_BITS-1:0]     o_readdata,
    output logic                     o_readdatavalid
);

    state_t               state;
    state_t               state_next;
    logic [5:0]           opcode;
    logic                 taken;
    logic                 entered;
    logic [DATA_BITS-1:0] wd_count;
    logic [DATA_BITS-1:0] timeout;
    logic                 run, step_mode, clear, step;
    logic                 wd_hit;
    logic                 unused_inst_bits;

    assign unused_inst_bits = ^i_inst[INST_BITS-7:0];

    // wd_count holds cycles already spent in the state, so the limit is hit on the TIMEOUT-th cycle.
    assign wd_hit = (timeout != '0) && is_watched(state) && (wd_count >= timeout - DATA_BITS'(1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            opcode   <= '0;
            taken    <= 1'b0;
            entered  <= 1'b0;
            wd_count <= '0;
        end else begin
            entered <= (state_next != state);
            if ((state == ST_WAIT_INST) && i_inst_valid) begin
                opcode <= i_inst[INST_BITS-1 -: 6];
            end
            taken <= (state == ST_BRANCH) &&
                     ((opcode == OP_BE) ? (i_src0 == i_src1) : (i_src0 != i_src1));
            if (state_next != state) begin
                wd_count <= '0;
            end else if (is_watched(state) && (wd_count != '1)) begin
                wd_count <= wd_count + DATA_BITS'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:      if (run || (step && step_mode)) state_next = ST_FETCH;
            ST_FETCH:     if (!i_empty) state_next = ST_WAIT_INST;
                          else if (wd_hit) state_next = ST_ERROR;
            ST_WAIT_INST: if (i_inst_valid) state_next = ST_DECODE;
                          else if (wd_hit) state_next = ST_ERROR;
            ST_DECODE: begin
                case (opcode)
                    OP_NOP:          state_next = ST_RETIRE;
                    OP_ALU:          state_next = ST_CALC;
                    OP_LOAD:         state_next = ST_MEM_RD;
                    OP_STORE:        state_next = ST_MEM_WR;
                    OP_BE, OP_BNE:   state_next = ST_BRANCH;
                    OP_HALT:         state_next = ST_HALT;
                    default:         state_next = ST_ERROR;
                endcase
            end
            ST_CALC:      if (i_calc_complete) state_next = ST_RETIRE;
                          else if (wd_hit) state_next = ST_ERROR;
            ST_MEM_RD:    if (i_read_mem_complete) state_next = ST_RETIRE;
                          else if (wd_hit) state_next = ST_ERROR;
            ST_MEM_WR:    if (i_write_mem_complete) state_next = ST_RETIRE;
                          else if (wd_hit) state_next = ST_ERROR;
            ST_BRANCH:    state_next = ST_RETIRE;
            ST_RETIRE:    state_next = (run && !step_mode) ? ST_FETCH : ST_IDLE;
            ST_HALT,
            ST_ERROR:     if (clear) state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_fetch_req       = (state == ST_FETCH) && !i_empty;
        o_calc_start      = (state == ST_CALC) && entered;
        o_calc_op         = o_calc_start ? opcode : 6'd0;
        o_read_mem_start  = (state == ST_MEM_RD) && entered;
        o_write_mem_start = (state == ST_MEM_WR) && entered;
        o_inst_complete   = (state == ST_RETIRE);
        o_be_bne          = (state == ST_RETIRE) && taken;
        o_halted          = (state == ST_HALT);
        o_error           = (state == ST_ERROR);
    end

    cpu_ctrl_csr #(
        .DATA_BITS     (DATA_BITS),
        .CSR_ADDR_BITS (CSR_ADDR_BITS),
        .TIMEOUT_RST   (TIMEOUT_RST)
    ) u_csr (
        .clk           (clk),
        .rst           (rst),
        .addr          (i_addr),
        .read          (i_read),
        .write         (i_write),
        .writedata     (i_writedata),
        .readdata      (o_readdata),
        .readdatavalid (o_readdatavalid),
        .fsm_state     (state),
        .halted        (o_halted),
        .error         (o_error),
        .inst_done     (o_inst_complete),
        .stall         ((state == ST_FETCH) && i_empty),
        .run           (run),
        .step_mode     (step_mode),
        .clear         (clear),
        .step          (step),
        .timeout       (timeout)
    );

endmodule
